// File: rtl/pulse_timer_if.sv
// rtl/pulse_timer_if.sv - handshake and pulse signals between scaler stage and pulse_timer
interface pulse_timer_if;
   logic        rdy_in;
   logic [31:0] time_in;
   logic        akn_out;
   logic        pulse_out;
   logic        period_start;

   modport master (
      output rdy_in,
      output time_in,
      input  akn_out,
      input  pulse_out,
      input  period_start
   );

   modport slave (
      input  rdy_in,
      input  time_in,
      output akn_out,
      output pulse_out,
      output period_start
   );
endinterface

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - repeating frame pulse whose width is loaded via a four-phase rdy/akn handshake
// New widths are held in a pending slot and only promoted at a frame boundary.
module pulse_timer #(
   parameter logic [31:0] PERIOD = 32'd1_000_000
) (
   input  logic         clk,
   input  logic         reset,
   pulse_timer_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   state_t      r_state;
   logic        r_akn;
   logic        r_pulse;
   logic        r_period_start;
   logic        r_running;
   logic        r_pend_valid;
   logic [31:0] r_cnt;
   logic [31:0] r_pending;
   logic [31:0] r_active;

   logic        w_wrap;
   logic        w_capture;
   logic [31:0] w_clamped;
   logic [31:0] w_cnt_next;
   logic [31:0] w_active_next;

   assign w_wrap        = (r_cnt == PERIOD - 32'd1);
   assign w_capture     = (r_state == ST_IDLE) && bus.rdy_in;
   assign w_clamped     = (bus.time_in > PERIOD) ? PERIOD : bus.time_in;
   assign w_cnt_next    = w_wrap ? 32'd0 : r_cnt + 32'd1;
   assign w_active_next = (w_wrap && r_pend_valid) ? r_pending : r_active;

   // Outputs are registered from next-state values so they line up with r_cnt.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_akn          <= 1'b0;
         r_pulse        <= 1'b0;
         r_period_start <= 1'b0;
         r_running      <= 1'b0;
         r_pend_valid   <= 1'b0;
         r_cnt          <= 32'd0;
         r_pending      <= 32'd0;
         r_active       <= 32'd0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (bus.rdy_in) begin
                  r_pending <= w_clamped;
                  r_akn     <= 1'b1;
                  r_state   <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!bus.rdy_in) begin
                  r_akn   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
         endcase

         // The first edge after reset opens frame 0 with cnt still at 0.
         if (!r_running) begin
            r_running      <= 1'b1;
            r_period_start <= 1'b1;
            r_pulse        <= (32'd0 < r_active);
         end else begin
            r_cnt          <= w_cnt_next;
            r_period_start <= w_wrap;
            r_pulse        <= (w_cnt_next < w_active_next);
            if (w_wrap) begin
               r_active     <= w_active_next;
               r_pend_valid <= 1'b0;
            end
         end

         // A capture on the wrap edge overrides the clear so it lands next frame.
         if (w_capture) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign bus.akn_out      = r_akn;
   assign bus.pulse_out    = r_pulse;
   assign bus.period_start = r_period_start;

endmodule

// File: tb/tb_pulse_timer.sv
// tb/tb_pulse_timer.sv - randomized bench for pulse_timer against a frame-level reference model
module tb_pulse_timer;

   localparam int P = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   pulse_timer_if bus ();

   pulse_timer #(.PERIOD(32'd100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: m_c is the cycle index since reset release, m_cur the width of the
   // current frame, m_next the width the following frame will use.
   int m_c = -1;
   int m_cur = 0;
   int m_next = 0;
   bit m_acked = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_c = -1;
         m_cur = 0;
         m_next = 0;
         m_acked = 1'b0;
      end else begin
         m_c = m_c + 1;
         if (m_c > 0 && (m_c % P) == 0) m_cur = m_next;
         if (!m_acked && bus.rdy_in) begin
            m_next = (bus.time_in > 32'(P)) ? P : int'(bus.time_in);
            m_acked = 1'b1;
         end else if (m_acked && !bus.rdy_in) begin
            m_acked = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("akn_out", 32'(bus.akn_out), 32'(m_acked));
      check("pulse_out", 32'(bus.pulse_out), 32'((m_c >= 0) && ((m_c % P) < m_cur)));
      check("period_start", 32'(bus.period_start), 32'((m_c >= 0) && ((m_c % P) == 0)));
   end

   task automatic wait_akn(input logic lvl);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.akn_out === lvl) seen = 1'b1;
      end
      check("akn_wait_timeout", 32'(seen), 32'd1);
   endtask

   task automatic handshake(input logic [31:0] v, input int hold);
      bus.rdy_in = 1'b1;
      bus.time_in = v;
      wait_akn(1'b1);
      repeat (hold) @(negedge clk);
      bus.rdy_in = 1'b0;
      wait_akn(1'b0);
   endtask

   task automatic wait_frame_start();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 250 && !seen; i++) begin
         @(negedge clk);
         if (bus.period_start === 1'b1) seen = 1'b1;
      end
      check("frame_start_timeout", 32'(seen), 32'd1);
   endtask

   task automatic count_frame(output int h);
      wait_frame_start();
      h = int'(bus.pulse_out);
      for (int i = 1; i < P; i++) begin
         @(negedge clk);
         h = h + int'(bus.pulse_out);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h;
      int ps;
      logic [31:0] v;
      bus.rdy_in = 1'b0;
      bus.time_in = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      h = 0;
      ps = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         h = h + int'(bus.pulse_out);
         ps = ps + int'(bus.period_start);
      end
      check("idle_strobes", 32'(ps), 32'd3);
      check("idle_pulse_high", 32'(h), 32'd0);

      handshake(32'd30, 0);
      count_frame(h);
      check("width_30", 32'(h), 32'd30);

      handshake(32'd0, 1);
      count_frame(h);
      check("width_0", 32'(h), 32'd0);
      handshake(32'd100, 0);
      count_frame(h);
      check("width_100", 32'(h), 32'd100);
      handshake(32'd500, 2);
      count_frame(h);
      check("width_500_clamped", 32'(h), 32'd100);

      wait_frame_start();
      handshake(32'd20, 0);
      handshake(32'd70, 0);
      count_frame(h);
      check("last_capture_wins", 32'(h), 32'd70);

      wait_frame_start();
      handshake(32'd10, 0);
      for (int i = 0; i < 120 && (m_c % P) != 99; i++) @(negedge clk);
      bus.rdy_in = 1'b1;
      bus.time_in = 32'd40;
      h = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         if (bus.akn_out) bus.rdy_in = 1'b0;
         h = h + int'(bus.pulse_out);
      end
      check("wrap_old_pending", 32'(h), 32'd10);
      h = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         h = h + int'(bus.pulse_out);
      end
      check("wrap_new_pending", 32'(h), 32'd40);

      wait_frame_start();
      bus.rdy_in = 1'b1;
      bus.time_in = 32'd77;
      @(negedge clk);
      check("pre_reset_akn", 32'(bus.akn_out), 32'd1);
      check("pre_reset_pulse", 32'(bus.pulse_out), 32'd1);
      reset = 1'b1;
      bus.rdy_in = 1'b0;
      @(negedge clk);
      check("reset_akn", 32'(bus.akn_out), 32'd0);
      check("reset_pulse", 32'(bus.pulse_out), 32'd0);
      check("reset_strobe", 32'(bus.period_start), 32'd0);
      reset = 1'b0;
      count_frame(h);
      check("post_reset_low_frame", 32'(h), 32'd0);
      handshake(32'd55, 1);
      count_frame(h);
      check("post_reset_width_55", 32'(h), 32'd55);

      for (int n = 0; n < 24; n++) begin
         repeat ($urandom_range(0, 150)) @(negedge clk);
         case ($urandom_range(0, 3))
            0: v = 32'd0;
            1: v = 32'd100;
            2: v = 32'd101 + $urandom_range(0, 100000);
            default: v = 32'($urandom_range(0, 100));
         endcase
         handshake(v, $urandom_range(0, 4));
      end
      repeat (250) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
